// File: rtl/dense_output_layer_if.sv
// dense_output_layer_if: activation, weight-memory and logit signals of dense_output_layer
//   act_in/in_valid/in_ready: input vector handshake
//   w_rd/w_addr/w_data: synchronous weight-memory read port (data one cycle after w_rd)
//   neuron_outputs/out_valid/busy: logits and status
interface dense_output_layer_if #(parameter int N_IN = 32, N_OUT = 10, DW = 16, AW = 9);
  logic [N_IN*DW-1:0] act_in;
  logic in_valid, in_ready;
  logic w_rd;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic [N_OUT*DW-1:0] neuron_outputs;
  logic out_valid, busy;
  modport master (output act_in, in_valid, w_data, input in_ready, w_rd, w_addr, neuron_outputs, out_valid, busy);
  modport slave (input act_in, in_valid, w_data, output in_ready, w_rd, w_addr, neuron_outputs, out_valid, busy);
endinterface

// File: rtl/dense_output_layer.sv
// dense_output_layer: serial Q8.8 fully-connected output layer fed from an external weight memory
//   clk, rst: clock, synchronous active-high reset
//   bus (slave): act_in/in_valid/in_ready, w_rd/w_addr/w_data, neuron_outputs/out_valid/busy
module dense_output_layer #(
  parameter int N_IN  = 32,
  parameter int N_OUT = 10,
  parameter int DW    = 16,
  parameter int AW    = 9,
  parameter int ACC_W = 40
) (
  input logic clk,
  input logic rst,
  dense_output_layer_if.slave bus
);
  localparam int IW = $clog2(N_IN + 1);
  localparam int JW = $clog2(N_OUT + 1);
  localparam logic [AW-1:0] BIAS_BASE = AW'(N_OUT * N_IN);
  localparam logic signed [ACC_W-1:0] SMAX = 32767;
  localparam logic signed [ACC_W-1:0] SMIN = -32768;
  typedef enum logic [2:0] {IDLE, BIAS, MAC, DRAIN, STORE, DONE} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_i, w_ai;
  logic [JW-1:0] r_j;
  logic [N_IN*DW-1:0] r_act;
  logic [N_OUT*DW-1:0] r_out;
  logic signed [ACC_W-1:0] r_acc, w_acc, w_shift;
  logic signed [2*DW-1:0] w_prod;
  logic [DW-1:0] w_sat;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.in_valid ? BIAS : IDLE;
      BIAS:    w_next = MAC;
      MAC:     w_next = (r_i == IW'(N_IN - 1)) ? DRAIN : MAC;
      DRAIN:   w_next = STORE;
      STORE:   w_next = (r_j == JW'(N_OUT - 1)) ? DONE : BIAS;
      default: w_next = IDLE;
    endcase
  end
  // w_data always answers the previous cycle's read, so the activation index lags r_i by one
  assign w_ai = r_i - 1'b1;
  assign w_prod = $signed(r_act[w_ai*DW +: DW]) * $signed(bus.w_data);
  // first MAC cycle receives the bias, aligned to Q16.16 by the 8-bit shift
  assign w_acc = (r_state == MAC && r_i == '0)
               ? {{(ACC_W-DW-8){bus.w_data[DW-1]}}, bus.w_data, 8'h00}
               : r_acc + {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};
  assign w_shift = r_acc >>> 8;
  assign w_sat = (w_shift > SMAX) ? SMAX[DW-1:0] : (w_shift < SMIN) ? SMIN[DW-1:0] : w_shift[DW-1:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_i <= '0;
      r_j <= '0;
      r_acc <= '0;
      r_act <= '0;
      r_out <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.in_valid) begin
        r_act <= bus.act_in;
        r_j <= '0;
      end
      if (r_state == BIAS) begin
        r_acc <= '0;
        r_i <= '0;
      end
      if (r_state == MAC) r_i <= r_i + 1'b1;
      if (r_state == MAC || r_state == DRAIN) r_acc <= w_acc;
      if (r_state == STORE) begin
        r_out[r_j*DW +: DW] <= w_sat;
        r_j <= r_j + 1'b1;
      end
    end
  end
  assign bus.in_ready = r_state == IDLE;
  assign bus.busy = r_state != IDLE;
  assign bus.out_valid = r_state == DONE;
  assign bus.w_rd = r_state == BIAS || r_state == MAC;
  assign bus.w_addr = (r_state == BIAS) ? BIAS_BASE + AW'(r_j)
                    : (r_state == MAC) ? AW'(r_j) * AW'(N_IN) + AW'(r_i) : '0;
  assign bus.neuron_outputs = r_out;
endmodule
